solve_ctrl: RTL and testbench

- Initiator side of the grid solver's start/done handshake.
- Conditions a raw push-button press and issues a one-cycle start pulse to the grid.
- Waits for done, with a timeout; latches the outcome and the solve time in cycles.
- Drives the 7-segment status glyph. Sits between the board-level top and the grid instance.

---
 rtl/sudoku_pkg.sv | 18 +
 rtl/key_debounce.sv | 45 ++++
 rtl/solve_ctrl.sv | 114 +++++++++++
 tb/tb_solve_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// Shared types and constants for the sudoku grid solver control path.
// Holds the solve FSM encoding, 7-segment glyphs (active-low, gfedcba) and clock rate.
package sudoku_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } solve_state_t;

  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_S    = 7'b0010010;
  localparam logic [6:0] SEG_F    = 7'b0001110;

  localparam int CLK_HZ = 50_000_000;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, one-cycle press event.
// o_press is high in the cycle before the debounced level falls; the level moves at the next edge.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_settled;

  // The Nth consecutive differing sample is the current one, so the level flips on this edge.
  assign w_settled = (r_sync2 != r_level) && (r_cnt == LAST);
  assign o_press   = w_settled && r_level;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (w_settled) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/solve_ctrl.sv
// Initiator of the grid solver start/done handshake: debounced key -> start pulse -> wait for done.
// Timeout exit from WAIT exists only when SOLVE_CTRL_TIMEOUT_EN is defined.
module solve_ctrl
  import sudoku_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = CLK_HZ / 50,
  parameter int TIMEOUT_CYCLES  = CLK_HZ * 10,
  parameter int CYCLE_CNT_W     = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start_key,
  output logic                   grid_start,
  input  logic                   grid_done,
  input  logic                   grid_success,
  output logic                   busy,
  output logic                   result_valid,
  output logic                   result_success,
  output logic                   timed_out,
  output logic [CYCLE_CNT_W-1:0] elapsed,
  output logic [6:0]             hex_status
);

  if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1 || CYCLE_CNT_W < 1) begin : g_bad_params
    $error("solve_ctrl: DEBOUNCE_CYCLES, TIMEOUT_CYCLES and CYCLE_CNT_W must be positive");
  end

  solve_state_t           r_state;
  solve_state_t           w_next;
  logic                   r_grid_start;
  logic                   r_success;
  logic                   r_timed_out;
  logic [CYCLE_CNT_W-1:0] r_elapsed;
  logic [CYCLE_CNT_W-1:0] w_elapsed_inc;
  logic                   w_press;
  logic                   w_timeout;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .i_clock  (clock),
    .i_reset_n(reset),
    .i_key_n  (start_key),
    .o_press  (w_press)
  );

`ifdef SOLVE_CTRL_TIMEOUT_EN
  localparam logic [CYCLE_CNT_W-1:0] TIMEOUT_LAST = CYCLE_CNT_W'(TIMEOUT_CYCLES - 1);
  assign w_timeout = (r_elapsed == TIMEOUT_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  assign w_elapsed_inc = (&r_elapsed) ? r_elapsed : r_elapsed + CYCLE_CNT_W'(1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_press) w_next = START;
      START:   w_next = WAIT;
      WAIT:    if (grid_done || w_timeout) w_next = DONE;
      DONE:    if (w_press) w_next = START;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_grid_start <= 1'b0;
      r_success    <= 1'b0;
      r_timed_out  <= 1'b0;
      r_elapsed    <= '0;
    end else begin
      r_state      <= w_next;
      r_grid_start <= (w_next == START);
      if (w_next == START) begin
        r_elapsed <= '0;
      end else if (r_state == WAIT) begin
        // grid_done has priority; a timeout exit freezes elapsed at its final value
        if (grid_done) begin
          r_success   <= grid_success;
          r_timed_out <= 1'b0;
          r_elapsed   <= w_elapsed_inc;
        end else if (w_timeout) begin
          r_success   <= 1'b0;
          r_timed_out <= 1'b1;
        end else begin
          r_elapsed <= w_elapsed_inc;
        end
      end
    end
  end

  always_comb begin
    busy         = 1'b0;
    result_valid = 1'b0;
    hex_status   = SEG_DASH;
    case (r_state)
      START, WAIT: busy = 1'b1;
      DONE: begin
        result_valid = 1'b1;
        hex_status   = r_success ? SEG_S : SEG_F;
      end
      default: ;
    endcase
  end

  assign grid_start     = r_grid_start;
  assign result_success = r_success;
  assign timed_out      = r_timed_out;
  assign elapsed        = r_elapsed;

endmodule

// File: tb/tb_solve_ctrl.sv
// Bench for solve_ctrl with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20, CYCLE_CNT_W=8.
// Inputs driven and outputs sampled on the falling edge; results checked through a queue.
`timescale 1ns/1ps
module tb_solve_ctrl;
  import sudoku_pkg::*;

  localparam int DEB = 4;
  localparam int TO  = 20;
  localparam int W   = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start_key = 1'b1;
  logic         grid_done = 1'b0;
  logic         grid_success = 1'b0;
  logic         grid_start;
  logic         busy;
  logic         result_valid;
  logic         result_success;
  logic         timed_out;
  logic [W-1:0] elapsed;
  logic [6:0]   hex_status;

  always #5 clock = ~clock;

  solve_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TO),
    .CYCLE_CNT_W    (W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start_key     (start_key),
    .grid_start    (grid_start),
    .grid_done     (grid_done),
    .grid_success  (grid_success),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_success(result_success),
    .timed_out     (timed_out),
    .elapsed       (elapsed),
    .hex_status    (hex_status)
  );

  typedef struct {
    logic       succ;
    logic       to;
    int         el;
    logic [6:0] hex;
  } exp_t;

  typedef struct {
    int   done_k;  // WAIT cycle on which the grid raises done; 0 = never
    logic succ;
    exp_t exp;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[5];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  // Returns the number of falling edges from the call until grid_start is seen, -1 if never.
  task automatic wait_start(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      cyc();
      if (grid_start === 1'b1) begin
        n = i;
        break;
      end
    end
    start_key = 1'b1;
    grid_done = 1'b0;
  endtask

  // Called in the START cycle; grid answers on WAIT cycle k, optional key press during WAIT.
  task automatic finish_run(input int k, input logic s, input exp_t e, input int press_at);
    int   extra;
    bit   got;
    exp_t x;
    extra = 0;
    got   = 1'b0;
    sb.push_back(e);
    chk("start_busy", busy, 1);
    chk("start_result_valid", result_valid, 0);
    chk("start_elapsed", elapsed, 0);
    for (int c = 1; c <= 400; c++) begin
      cyc();
      if (grid_start === 1'b1) extra++;
      if (result_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (press_at > 0 && c == press_at) start_key = 1'b0;
      if (press_at > 0 && c == press_at + 8) start_key = 1'b1;
      if (c == k) begin
        grid_done    = 1'b1;
        grid_success = s;
      end
    end
    start_key = 1'b1;
    chk("extra_grid_start", extra, 0);
    x = sb.pop_front();
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL result_wait: result_valid still 0 after 400 cycles, expected elapsed %0d", x.el);
    end else begin
      chk("result_success", result_success, x.succ);
      chk("timed_out", timed_out, x.to);
      chk("elapsed", elapsed, x.el);
      chk("hex_status", hex_status, x.hex);
      chk("done_busy", busy, 0);
    end
    repeat (8) cyc();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, expected summary before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;

    tbl[0] = '{3,  1'b0, '{1'b0, 1'b0, 3,  SEG_F}};
    tbl[1] = '{1,  1'b1, '{1'b1, 1'b0, 1,  SEG_S}};
    tbl[2] = '{20, 1'b1, '{1'b1, 1'b0, 20, SEG_S}};
    tbl[3] = '{19, 1'b0, '{1'b0, 1'b0, 19, SEG_F}};
`ifdef SOLVE_CTRL_TIMEOUT_EN
    tbl[4] = '{0,   1'b0, '{1'b0, 1'b1, 19,  SEG_F}};
`else
    tbl[4] = '{300, 1'b0, '{1'b0, 1'b0, 255, SEG_F}};
`endif

    // Reset held with the key pressed
    reset     = 1'b0;
    start_key = 1'b0;
    repeat (3) begin
      cyc();
      chk("rst_grid_start", grid_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_result_success", result_success, 0);
      chk("rst_timed_out", timed_out, 0);
      chk("rst_elapsed", elapsed, 0);
      chk("rst_hex", hex_status, SEG_DASH);
    end
    reset     = 1'b1;
    start_key = 1'b1;
    cnt = 0;
    repeat (12) begin
      cyc();
      if (grid_start === 1'b1) cnt++;
    end
    chk("post_reset_no_start", cnt, 0);

    // Bounce: 2-cycle toggles never settle, then a held press
    cnt = 0;
    for (int t = 0; t < 6; t++) begin
      start_key = (t % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) begin
        cyc();
        if (grid_start === 1'b1) cnt++;
      end
    end
    chk("bounce_no_start", cnt, 0);
    start_key = 1'b0;
    wait_start(n);
    chk("bounce_latency", n, 2 + DEB);
    finish_run(7, 1'b1, '{1'b1, 1'b0, 7, SEG_S}, 0);

    // Table runs, each re-started from DONE
    for (int v = 0; v < 5; v++) begin
      start_key = 1'b0;
      wait_start(n);
      chk("rerun_latency", n, 2 + DEB);
      finish_run(tbl[v].done_k, tbl[v].succ, tbl[v].exp, 0);
    end

    // Press during WAIT is dropped, not queued for DONE
    start_key = 1'b0;
    wait_start(n);
    chk("ignored_press_latency", n, 2 + DEB);
    finish_run(15, 1'b1, '{1'b1, 1'b0, 15, SEG_S}, 2);
    cnt = 0;
    repeat (10) begin
      cyc();
      if (grid_start === 1'b1 || result_valid !== 1'b1) cnt++;
    end
    chk("no_queued_press", cnt, 0);

    // Reset on WAIT cycle 5, then a late done arriving in IDLE
    start_key = 1'b0;
    wait_start(n);
    chk("midreset_latency", n, 2 + DEB);
    repeat (5) cyc();
    chk("midreset_pre_busy", busy, 1);
    chk("midreset_pre_elapsed", elapsed, 4);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("midreset_busy", busy, 0);
    chk("midreset_result_valid", result_valid, 0);
    chk("midreset_elapsed", elapsed, 0);
    chk("midreset_grid_start", grid_start, 0);
    chk("midreset_hex", hex_status, SEG_DASH);
    grid_done    = 1'b1;
    grid_success = 1'b1;
    cnt = 0;
    repeat (6) begin
      cyc();
      if (result_valid !== 1'b0 || busy !== 1'b0 || grid_start !== 1'b0) cnt++;
    end
    chk("idle_ignores_done", cnt, 0);
    chk("idle_hex", hex_status, SEG_DASH);
    grid_done = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
